pipeline_skid_stage: RTL and testbench

PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

---
 rtl/pipeline_skid_stage.sv | 137 +++++++++++++
 tb/tb_pipeline_skid_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_stage.sv
// One-entry pipeline stage with an optional skid register for registered backpressure.
// Define PIPE_SKID_EN to get the main+skid form with a registered o_ready; otherwise o_ready is combinational.
module pipeline_skid_stage #(
    parameter int unsigned   DW      = 96,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    // Encoding equals the number of held entries, so o_count is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic          in_fire, out_fire;

    assign o_valid  = (state_q != ST_EMPTY);
    assign o_data   = o_valid ? main_q : CLR_VAL;
    assign o_count  = 2'(state_q);
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

`ifdef PIPE_SKID_EN
    logic [DW-1:0] skid_q, skid_d;
    logic          ready_q;

    assign o_ready = ready_q;

    always_comb begin
        // NOTE: every signal gets its default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_BUSY;
                    main_d  = i_data;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = i_data;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = i_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any transfer, including one accepted this cycle.
        if (i_flush) begin
            state_d = ST_EMPTY;
            main_d  = CLR_VAL;
            skid_d  = CLR_VAL;
        end
    end

    // NOTE: payload registers sit on the async reset too, because reset must clear them without a clock edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
            main_q  <= CLR_VAL;
            skid_q  <= CLR_VAL;
            ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != ST_FULL);
        end
    end
`else
    // Without a skid slot the stage can only refill while it drains.
    assign o_ready = ~o_valid | i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_BUSY;
                    main_d  = i_data;
                end
            end
            ST_BUSY: begin
                if (out_fire) begin
                    if (in_fire) begin
                        main_d = i_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (i_flush) begin
            state_d = ST_EMPTY;
            main_d  = CLR_VAL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
            main_q  <= CLR_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed and scoreboard bench for pipeline_skid_stage; expectations follow PIPE_SKID_EN.
module tb_pipeline_skid_stage;

    localparam int          DW  = 96;
    localparam logic [95:0] CLR = 96'h0000_0000_0000_0000_0000_DEAD;
    localparam int          NPAY = 10000;

    logic          i_clk = 1'b0;
    logic          i_rstn, i_flush, i_valid, i_ready;
    logic [DW-1:0] i_data;
    logic          o_ready, o_valid;
    logic [DW-1:0] o_data;
    logic [1:0]    o_count;

    int vectors    = 0;
    int miscompares = 0;

    pipeline_skid_stage #(.DW(DW), .CLR_VAL(CLR)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_flush(i_flush),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
    endtask

    function automatic logic [DW-1:0] payload(input int n);
        return {32'(n) ^ 32'hA5A5_5A5A, 32'(n * 7), 32'(n)};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] sb_q[$];
        logic [DW-1:0] exp_d;
        int sent, rcvd, cycles;

        i_rstn  = 1'b1;
        i_flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        #2 i_rstn = 1'b0;
        #1;
        check("rst_valid", 96'(o_valid), 96'd0);
        check("rst_ready", 96'(o_ready), 96'd1);
        check("rst_count", 96'(o_count), 96'd0);
        check("rst_data",  o_data,       CLR);

        // Stream 1,2,3 at full rate; first accept on the first edge after release.
        @(negedge i_clk);
        i_rstn = 1'b1;
        drive(1'b1, 96'h1, 1'b1);
        tick();
        check("s1_data",  o_data,        96'h1);
        check("s1_count", 96'(o_count),  96'd1);
        i_data = 96'h2;
        tick();
        check("s2_data",  o_data,        96'h2);
        check("s2_count", 96'(o_count),  96'd1);
        i_data = 96'h3;
        tick();
        check("s3_data",  o_data,        96'h3);
        check("s3_count", 96'(o_count),  96'd1);
        i_valid = 1'b0;
        tick();
        check("s_drain_valid", 96'(o_valid), 96'd0);
        check("s_drain_data",  o_data,       CLR);
        check("s_drain_count", 96'(o_count), 96'd0);

`ifdef PIPE_SKID_EN
        // Stall while a second payload is accepted: it must land in the skid.
        drive(1'b1, 96'hA, 1'b1);
        tick();
        check("k_a_data", o_data, 96'hA);
        drive(1'b1, 96'hB, 1'b0);
        tick();
        check("k_full_count", 96'(o_count), 96'd2);
        check("k_full_ready", 96'(o_ready), 96'd0);
        check("k_full_data",  o_data,       96'hA);
        drive(1'b0, 96'h0, 1'b1);
        tick();
        check("k_b_data",  o_data,        96'hB);
        check("k_b_count", 96'(o_count),  96'd1);
        check("k_b_ready", 96'(o_ready),  96'd1);
        tick();
        check("k_end_count", 96'(o_count), 96'd0);
        check("k_end_valid", 96'(o_valid), 96'd0);

        // Flush from FULL with a payload offered in the same cycle.
        drive(1'b1, 96'hD, 1'b1);
        tick();
        drive(1'b1, 96'hE, 1'b0);
        tick();
        check("f_full_count", 96'(o_count), 96'd2);
        i_flush = 1'b1;
        drive(1'b1, 96'hC, 1'b0);
        tick();
        i_flush = 1'b0;
        drive(1'b0, 96'h0, 1'b1);
        check("f_valid", 96'(o_valid), 96'd0);
        check("f_data",  o_data,       CLR);
        check("f_count", 96'(o_count), 96'd0);
        check("f_ready", 96'(o_ready), 96'd1);
        tick();
        check("f_after_valid", 96'(o_valid), 96'd0);
`else
        // Combinational ready: stalled main blocks input until i_ready rises.
        drive(1'b1, 96'h7, 1'b0);
        tick();
        check("c_7_data", o_data, 96'h7);
        drive(1'b1, 96'h8, 1'b0);
        #1;
        check("c_stall_ready", 96'(o_ready), 96'd0);
        tick();
        check("c_hold_data",  o_data,       96'h7);
        check("c_hold_count", 96'(o_count), 96'd1);
        i_ready = 1'b1;
        #1;
        check("c_go_ready", 96'(o_ready), 96'd1);
        tick();
        check("c_8_data",  o_data,       96'h8);
        check("c_8_count", 96'(o_count), 96'd1);
        i_valid = 1'b0;
        tick();
        check("c_end_valid", 96'(o_valid), 96'd0);

        // Flush from BUSY with a payload that would otherwise be accepted.
        drive(1'b1, 96'hD, 1'b0);
        tick();
        check("f_busy_count", 96'(o_count), 96'd1);
        i_flush = 1'b1;
        drive(1'b1, 96'hC, 1'b1);
        tick();
        i_flush = 1'b0;
        drive(1'b0, 96'h0, 1'b1);
        check("f_valid", 96'(o_valid), 96'd0);
        check("f_data",  o_data,       CLR);
        check("f_count", 96'(o_count), 96'd0);
        check("f_ready", 96'(o_ready), 96'd1);
        tick();
        check("f_after_valid", 96'(o_valid), 96'd0);
`endif

        // Asynchronous reset between edges while holding 0x5.
        drive(1'b1, 96'h5, 1'b0);
        tick();
        i_valid = 1'b0;
        check("r_hold_data", o_data, 96'h5);
        #2 i_rstn = 1'b0;
        #1;
        check("r_async_valid", 96'(o_valid), 96'd0);
        check("r_async_data",  o_data,       CLR);
        check("r_async_count", 96'(o_count), 96'd0);
        check("r_async_ready", 96'(o_ready), 96'd1);
        @(negedge i_clk);
        i_rstn = 1'b1;
        drive(1'b1, 96'h9, 1'b1);
        tick();
        check("r_first_data", o_data, 96'h9);
        i_valid = 1'b0;
        tick();
        check("r_empty_valid", 96'(o_valid), 96'd0);

        // Random handshakes against an in-order scoreboard.
        sent   = 0;
        rcvd   = 0;
        cycles = 0;
        while (rcvd < NPAY && cycles < 90000) begin
            i_valid = (sent < NPAY) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_data  = payload(sent);
            i_ready = 1'($urandom_range(0, 1));
            #1;
            if (o_valid && i_ready) begin
                exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : CLR;
                check("sb_data", o_data, exp_d);
                rcvd++;
            end
            if (i_valid && o_ready) begin
                sb_q.push_back(i_data);
                sent++;
            end
            tick();
            cycles++;
        end
        check("sb_received", 96'(rcvd), 96'(NPAY));
        check("sb_leftover", 96'(sb_q.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
